// File: rtl/byte_unstriping_if.sv
// Bus bundle between the two-lane striper side and the byte unstriper.
// The master drives lane bytes and realign. The slave returns the merged stream and the per-lane status.
interface byte_unstriping_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic                  realign;
    logic [DATA_WIDTH-1:0] data_stripe_0;
    logic                  valid_stripe_0;
    logic [DATA_WIDTH-1:0] data_stripe_1;
    logic                  valid_stripe_1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [FILL_W-1:0]     fill_0;
    logic [FILL_W-1:0]     fill_1;
    logic                  overflow_0;
    logic                  overflow_1;

    modport master (
        output realign, data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1,
        input  data_out, valid_out, fill_0, fill_1, overflow_0, overflow_1
    );

    modport slave (
        input  realign, data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1,
        output data_out, valid_out, fill_0, fill_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/byte_unstriping.sv
// Merges two striped byte lanes back into one stream. Lane 0 carries the even bytes and is read first.
// Each lane has its own FIFO to absorb the skew between lanes. An overflow on either lane sets a sticky flag.
module byte_unstriping #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input logic              clk_2f,
    input logic              reset,
    byte_unstriping_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {LANE_0 = 1'b0, LANE_1 = 1'b1} lane_t;

    lane_t                 sel;
    lane_t                 sel_next;
    logic [PW-1:0]         wr_ptr [2];
    logic [PW-1:0]         rd_ptr [2];
    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    logic [DATA_WIDTH-1:0] lane_data [2];
    logic [1:0]            lane_valid;
    logic [1:0]            empty;
    logic [1:0]            full;
    logic [1:0]            pop;
    logic [1:0]            push;
    logic [1:0]            drop;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [1:0]            overflow;

    assign lane_valid   = {bus.valid_stripe_1, bus.valid_stripe_0};
    assign lane_data[0] = bus.data_stripe_0;
    assign lane_data[1] = bus.data_stripe_1;

    // A full lane can still accept a byte on an edge where its head is popped.
    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        drop  = '0;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] ^ rd_ptr[i]) == PW'(DEPTH));
        end
        pop[0] = !bus.realign && (sel == LANE_0) && !empty[0];
        pop[1] = !bus.realign && (sel == LANE_1) && !empty[1];
        for (int i = 0; i < 2; i++) begin
            push[i] = !bus.realign && lane_valid[i] && (!full[i] || pop[i]);
            drop[i] = !bus.realign && lane_valid[i] && full[i] && !pop[i];
        end
        head = (sel == LANE_0) ? mem[0][rd_ptr[0][AW-1:0]] : mem[1][rd_ptr[1][AW-1:0]];
    end

    always_comb begin
        sel_next = sel;
        if (bus.realign)
            sel_next = LANE_0;
        else if (|pop)
            sel_next = (sel == LANE_0) ? LANE_1 : LANE_0;
    end

    always_ff @(posedge clk_2f) begin
        if (reset)
            sel <= LANE_0;
        else
            sel <= sel_next;
    end

    // Realign flushes the datapath the same way reset does, but it keeps the sticky overflow flags.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            data_q   <= '0;
            valid_q  <= 1'b0;
            overflow <= '0;
        end else if (bus.realign) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (drop[i])
                    overflow[i] <= 1'b1;
            end
            valid_q <= |pop;
            data_q  <= (|pop) ? head : '0;
        end
    end

    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i])
                mem[i][wr_ptr[i][AW-1:0]] <= lane_data[i];
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.fill_0     = wr_ptr[0] - rd_ptr[0];
    assign bus.fill_1     = wr_ptr[1] - rd_ptr[1];
    assign bus.overflow_0 = overflow[0];
    assign bus.overflow_1 = overflow[1];
endmodule
